rf_wb_queue: RTL and testbench
==============================

Name: rf_wb_queue

Overview:
Write-back queue on the initiator side of the register-file write port. It collects write-back results from producers over a valid/ready handshake and buffers them in order. It drains one entry per granted cycle onto the register file's wen/waddr/wdata port. While an entry is still queued, it also forwards the youngest pending value to the two register-file read addresses, so readers never see stale data.

Parameters:
DATA_WIDTH, 32, write-data width; matches the register-file data width
ADDR_WIDTH, 5, register index width
DEPTH, 4, queue entries; power of two, at least 2

Ports:
clk  in  1  clock; all state updates on posedge
resetn  in  1  asynchronous, active-low reset
in_valid  in  1  producer has a result
in_ready  out  1  queue can accept; equals !full, with no combinational path from rf_gnt
in_waddr  in  ADDR_WIDTH  destination register
in_wdata  in  DATA_WIDTH  result value
rf_gnt  in  1  register-file write port is available this cycle
rf_wen  out  1  drives register-file wen
rf_waddr  out  ADDR_WIDTH  drives register-file waddr
rf_wdata  out  DATA_WIDTH  drives register-file wdata
raddr1  in  ADDR_WIDTH  read address 1, mirrored from the register-file read port
raddr2  in  ADDR_WIDTH  read address 2
fwd_hit1  out  1  a pending entry matches raddr1
fwd_data1  out  DATA_WIDTH  youngest pending data for raddr1
fwd_hit2  out  1  a pending entry matches raddr2
fwd_data2  out  DATA_WIDTH  youngest pending data for raddr2
empty  out  1  no pending entries

Behaviour:
- Reset (resetn=0, asynchronous): head, tail and count are 0; all entry valid bits are 0. Resulting outputs: empty=1, in_ready=1, rf_wen=0, fwd_hit1/2=0. rf_waddr, rf_wdata and fwd_data1/2 are 0.
- Storage: circular buffer of DEPTH entries {waddr, wdata}, with head/tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0. count is log2(DEPTH)+1 bits; full = (count==DEPTH).
- Push: a handshake (in_valid && in_ready) at posedge writes the entry at tail and advances tail.
- Writes to register 0: accepted (handshake completes) but not enqueued; pointers and count are unchanged.
- Drain outputs are combinational from the head entry:
  - rf_wen = !empty && rf_gnt
  - rf_waddr = head.waddr and rf_wdata = head.wdata when !empty, else 0
- Pop: rf_wen=1 at posedge advances head. The register file commits the value on the same edge.
- Latency: a result accepted at edge k is presented at the register-file port during cycle k+1. With rf_gnt=1 it is written at edge k+1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- When full, in_ready=0 even if rf_gnt=1 in that cycle (no pop-through).
- Forwarding: fwd_hitN=1 if any valid entry, head included, has waddr==raddrN and raddrN!=0. fwd_dataN is the data of the youngest such entry, searched from tail-1 back to head. When there is no hit, fwd_dataN=0.
- Consumer rule: operand = fwd_hitN ? fwd_dataN : rdataN. The entry being popped this cycle still forwards; after the edge the register file holds that value.
- Ordering: register-file writes occur in acceptance order. Multiple writes to the same register all drain; the last one wins.
- Reset mid-operation: pending entries are discarded and are never written.

Optional Feature:
RF_WBQ_STATS_EN
- Defined: adds output stall_cnt [31:0], reset to 0. It increments on every cycle with in_valid && !in_ready and saturates at 32'hFFFF_FFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: DATA_WIDTH and ADDR_WIDTH constants, shared with the register file. Also the entry typedef {waddr, wdata}.
- One sub-module, rf_wbq_fwd_search: purely combinational youngest-match search over the entry array, given head and count. It is instantiated twice, once per read port.

Test Plan:
- Reset then idle: empty=1, in_ready=1, rf_wen=0, fwd_hit1=0 for raddr1=3.
- Push {r5, 32'hDEAD_BEEF} with rf_gnt=1:
  - next cycle: rf_wen=1, rf_waddr=5, rf_wdata=32'hDEAD_BEEF
  - that cycle, raddr1=5 gives fwd_hit1=1, fwd_data1=32'hDEAD_BEEF
  - cycle after: empty=1
- rf_gnt=0, push r1..r4 (data 1..4): after the 4th push in_ready=0. Then rf_gnt=1: writes r1, r2, r3, r4 in order on 4 consecutive edges; in_ready returns 1 the cycle after the first pop.
- rf_gnt=0, push {r7,32'h11} then {r7,32'h22}: raddr2=7 gives fwd_data2=32'h22. Drain order is 32'h11, then 32'h22.
- Push {r0, 32'hFFFF}: handshake completes, empty stays 1, rf_wen never asserts. raddr1=0 gives fwd_hit1=0.
- Fill to 3 entries, assert resetn=0 mid-cycle: outputs go to reset values immediately, and after release no rf_wen pulse occurs.
- (RF_WBQ_STATS_EN) Full queue with in_valid=1 for 5 cycles: stall_cnt=5.

Source files
------------

// File: rtl/rf_wb_queue_pkg.sv
// Shared constants and entry type for the register-file write-back queue.
// Widths match the register file so both sides agree on the entry layout.
package rf_wb_queue_pkg;

  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_ADDR_WIDTH = 5;

  // One pending write-back: destination register and value.
  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0] waddr;
    logic [RF_DATA_WIDTH-1:0] wdata;
  } rf_wbq_entry_t;

endpackage

// File: rtl/rf_wbq_fwd_search.sv
// Youngest-match search over the write-back queue entries for one read address.
// Purely combinational; walks from head (oldest) towards tail so later matches
// overwrite earlier ones and the youngest pending value wins.
module rf_wbq_fwd_search #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned PtrW      = $clog2(DEPTH),
  localparam int unsigned CntW      = PtrW + 1
) (
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] i_waddr,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] i_wdata,
  input  logic [DEPTH-1:0]                 i_valid,
  input  logic [PtrW-1:0]                  i_head,
  input  logic [CntW-1:0]                  i_count,
  input  logic [ADDR_WIDTH-1:0]            i_raddr,
  output logic                             o_hit,
  output logic [DATA_WIDTH-1:0]            o_data
);

  logic [PtrW-1:0] w_idx;

  // Oldest-to-youngest scan; register 0 never forwards.
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_idx = i_head + PtrW'(i);
      if ((CntW'(i) < i_count) && i_valid[w_idx] && (i_raddr != '0) &&
          (i_waddr[w_idx] == i_raddr)) begin
        o_hit  = 1'b1;
        o_data = i_wdata[w_idx];
      end
    end
  end

endmodule

// File: rtl/rf_wb_queue.sv
// In-order write-back queue in front of the register-file write port, with
// read-port forwarding of the youngest pending value.
// Optional build macro RF_WBQ_STATS_EN adds a saturating producer-stall counter.
module rf_wb_queue
  import rf_wb_queue_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_waddr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic                  rf_gnt,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  fwd_hit1,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic                  fwd_hit2,
  output logic [DATA_WIDTH-1:0] fwd_data2,
  output logic                  empty
`ifdef RF_WBQ_STATS_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] r_waddr;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_wdata;
  logic [DEPTH-1:0]                 r_valid;
  logic [PtrW-1:0]                  r_head;
  logic [PtrW-1:0]                  r_tail;
  logic [CntW-1:0]                  r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // in_ready depends only on state, so there is no path from rf_gnt; a full
  // queue refuses even when it is draining this cycle.
  assign w_full   = (r_count == CntW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  assign empty    = w_empty;

  // Writes to r0 complete the handshake but are dropped.
  assign w_push = in_valid && in_ready && (in_waddr != '0);
  assign w_pop  = !w_empty && rf_gnt;

  // Drain port is driven straight from the head entry.
  always_comb begin
    rf_wen   = w_pop;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!w_empty) begin
      rf_waddr = r_waddr[r_head];
      rf_wdata = r_wdata[r_head];
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PtrW'(1);
      if (w_pop)  r_head <= r_head + PtrW'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  // Entry storage and per-entry valid bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_waddr <= '0;
      r_wdata <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) r_valid[r_head] <= 1'b0;
      if (w_push) begin
        r_waddr[r_tail] <= in_waddr;
        r_wdata[r_tail] <= in_wdata;
        r_valid[r_tail] <= 1'b1;
      end
    end
  end

  rf_wbq_fwd_search #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fwd1 (
    .i_waddr (r_waddr),
    .i_wdata (r_wdata),
    .i_valid (r_valid),
    .i_head  (r_head),
    .i_count (r_count),
    .i_raddr (raddr1),
    .o_hit   (fwd_hit1),
    .o_data  (fwd_data1)
  );

  rf_wbq_fwd_search #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fwd2 (
    .i_waddr (r_waddr),
    .i_wdata (r_wdata),
    .i_valid (r_valid),
    .i_head  (r_head),
    .i_count (r_count),
    .i_raddr (raddr2),
    .o_hit   (fwd_hit2),
    .o_data  (fwd_data2)
  );

`ifdef RF_WBQ_STATS_EN
  logic [31:0] r_stall_cnt;

  // Count cycles where a producer is held off; saturate rather than wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (in_valid && !in_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed self-checking bench for rf_wb_queue (DEPTH=4).
module tb_rf_wb_queue;
  import rf_wb_queue_pkg::*;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;
  logic        rf_gnt;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
  logic        fwd_hit2;
  logic [31:0] fwd_data2;
  logic        empty;
`ifdef RF_WBQ_STATS_EN
  logic [31:0] stall_cnt;
`endif

  int unsigned n_chk;
  int unsigned n_pass;

  rf_wbq_entry_t wr_log[$];

  rf_wb_queue #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .DEPTH      (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_waddr  (in_waddr),
    .in_wdata  (in_wdata),
    .rf_gnt    (rf_gnt),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_data1 (fwd_data1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data2 (fwd_data2),
    .empty     (empty)
`ifdef RF_WBQ_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every register-file write; inputs are stable mid-cycle, so what is
  // seen on the falling edge is what commits on the next rising edge.
  always @(negedge clk) begin
    if (rf_wen) wr_log.push_back('{waddr: rf_waddr, wdata: rf_wdata});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string tag, input int idx, input logic [4:0] a,
                           input logic [31:0] d);
    if (idx < wr_log.size()) begin
      check({tag, "_addr"}, 64'(wr_log[idx].waddr), 64'(a));
      check({tag, "_data"}, 64'(wr_log[idx].wdata), 64'(d));
    end else begin
      check({tag, "_present"}, 64'(wr_log.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_waddr = '0;
    in_wdata = '0;
    rf_gnt   = 1'b0;
    raddr1   = 5'd3;
    raddr2   = 5'd0;

    // Reset and idle
    step();
    step();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_wen", 64'(rf_wen), 64'd0);
    check("rst_hit1", 64'(fwd_hit1), 64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);
    check("rst_fdata1", 64'(fwd_data1), 64'd0);
    resetn = 1'b1;
    step();
    check("idle_empty", 64'(empty), 64'd1);
    check("idle_hit1", 64'(fwd_hit1), 64'd0);

    // Single push with grant: presented the next cycle, gone the one after
    wr_log.delete();
    rf_gnt   = 1'b1;
    in_valid = 1'b1;
    in_waddr = 5'd5;
    in_wdata = 32'hDEAD_BEEF;
    #1;
    check("p1_ready", 64'(in_ready), 64'd1);
    check("p1_wen_before", 64'(rf_wen), 64'd0);
    step();
    in_valid = 1'b0;
    raddr1   = 5'd5;
    #1;
    check("p1_wen", 64'(rf_wen), 64'd1);
    check("p1_waddr", 64'(rf_waddr), 64'd5);
    check("p1_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    check("p1_hit1", 64'(fwd_hit1), 64'd1);
    check("p1_fdata1", 64'(fwd_data1), 64'hDEAD_BEEF);
    step();
    check("p1_empty", 64'(empty), 64'd1);
    check("p1_hit1_after", 64'(fwd_hit1), 64'd0);
    check("p1_nwrites", 64'(wr_log.size()), 64'd1);
    check_log("p1_log", 0, 5'd5, 32'hDEAD_BEEF);

    // Fill to full with no grant, then drain in order
    wr_log.delete();
    rf_gnt = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_waddr = 5'(i);
      in_wdata = 32'(i);
      #1;
      check($sformatf("fill%0d_ready", i), 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    #1;
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_empty", 64'(empty), 64'd0);
    check("full_wen", 64'(rf_wen), 64'd0);
    // Offer a push while granted: still refused, no pop-through.
    in_valid = 1'b1;
    in_waddr = 5'd9;
    in_wdata = 32'h9;
    rf_gnt   = 1'b1;
    #1;
    check("full_gnt_ready", 64'(in_ready), 64'd0);
    check("full_gnt_wen", 64'(rf_wen), 64'd1);
    check("full_gnt_waddr", 64'(rf_waddr), 64'd1);
    in_valid = 1'b0;
    step();
    check("pop1_ready", 64'(in_ready), 64'd1);
    check("pop1_waddr", 64'(rf_waddr), 64'd2);
    step();
    step();
    step();
    rf_gnt = 1'b0;
    #1;
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_nwrites", 64'(wr_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_log($sformatf("drain%0d", i), i, 5'(i + 1), 32'(i + 1));
    end

    // Two writes to r7: youngest forwards, both drain in order
    wr_log.delete();
    in_valid = 1'b1;
    in_waddr = 5'd7;
    in_wdata = 32'h11;
    step();
    in_wdata = 32'h22;
    step();
    in_valid = 1'b0;
    raddr2   = 5'd7;
    raddr1   = 5'd5;
    #1;
    check("r7_hit2", 64'(fwd_hit2), 64'd1);
    check("r7_fdata2", 64'(fwd_data2), 64'h22);
    check("r7_hit1_miss", 64'(fwd_hit1), 64'd0);
    check("r7_fdata1_miss", 64'(fwd_data1), 64'd0);
    rf_gnt = 1'b1;
    step();
    check("r7_fdata2_after", 64'(fwd_data2), 64'h22);
    step();
    rf_gnt = 1'b0;
    #1;
    check("r7_hit2_gone", 64'(fwd_hit2), 64'd0);
    check("r7_nwrites", 64'(wr_log.size()), 64'd2);
    check_log("r7_first", 0, 5'd7, 32'h11);
    check_log("r7_second", 1, 5'd7, 32'h22);

    // Write to r0: accepted but dropped
    wr_log.delete();
    rf_gnt   = 1'b1;
    in_valid = 1'b1;
    in_waddr = 5'd0;
    in_wdata = 32'hFFFF;
    raddr1   = 5'd0;
    #1;
    check("r0_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    #1;
    check("r0_empty", 64'(empty), 64'd1);
    check("r0_wen", 64'(rf_wen), 64'd0);
    check("r0_hit1", 64'(fwd_hit1), 64'd0);
    step();
    check("r0_nwrites", 64'(wr_log.size()), 64'd0);

    // Reset mid-operation discards pending entries
    wr_log.delete();
    rf_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_waddr = 5'(10 + i);
      in_wdata = 32'h100 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    raddr1   = 5'd10;
    #1;
    check("mr_pre_hit1", 64'(fwd_hit1), 64'd1);
    check("mr_pre_empty", 64'(empty), 64'd0);
    resetn = 1'b0;
    rf_gnt = 1'b1;
    #1;
    check("mr_empty", 64'(empty), 64'd1);
    check("mr_ready", 64'(in_ready), 64'd1);
    check("mr_wen", 64'(rf_wen), 64'd0);
    check("mr_waddr", 64'(rf_waddr), 64'd0);
    check("mr_hit1", 64'(fwd_hit1), 64'd0);
    step();
    resetn = 1'b1;
    step();
    step();
    step();
    check("mr_post_empty", 64'(empty), 64'd1);
    check("mr_nwrites", 64'(wr_log.size()), 64'd0);

`ifdef RF_WBQ_STATS_EN
    // Stall counter: full queue with a producer waiting for 5 edges
    rf_gnt = 1'b0;
    check("st_zero", 64'(stall_cnt), 64'd0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_waddr = 5'(20 + i);
      in_wdata = 32'(i);
      step();
    end
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    #1;
    check("st_cnt", 64'(stall_cnt), 64'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
